// File: rtl/gpu_axis_loader.sv
// AXI-Stream ingress loader: one header beat selects a target memory port and base word address,
// following payload beats are written there. Optional wrap guard: GPU_AXIS_LOADER_WRAP_GUARD_EN.
module gpu_axis_loader #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned NUM_TARGETS = 2
) (
  input  logic                    axis_clk,
  input  logic                    axis_aresetn,
  input  logic [DATA_WIDTH-1:0]   axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] axis_tkeep,
  input  logic                    axis_tlast,
  input  logic                    axis_tvalid,
  output logic                    axis_tready,
  output logic [NUM_TARGETS-1:0]  mem_wr_en,
  input  logic [NUM_TARGETS-1:0]  mem_wr_ready,
  output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  output logic [DATA_WIDTH/8-1:0] mem_wr_be,
  output logic                    busy,
  output logic                    pkt_done,
  output logic [ADDR_WIDTH:0]     last_len,
  output logic                    err_bad_tgt,
`ifdef GPU_AXIS_LOADER_WRAP_GUARD_EN
  output logic                    err_overflow,
`endif
  input  logic                    err_clr
);

  typedef enum logic [1:0] {
    S_HDR     = 2'd0,
    S_PAYLOAD = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] CNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_tgt, w_tgt_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [ADDR_WIDTH:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [ADDR_WIDTH:0]   r_last_len, w_last_len_nxt;
  logic                  r_pkt_done, w_pkt_done_nxt;
  logic                  r_err_bad_tgt, w_set_bad_tgt;
  logic                  w_set_ovf;
  logic                  w_sel_ready;
  logic                  w_accept;
  logic [3:0]            w_hdr_tgt;
  logic                  w_hdr_bad;

  assign w_hdr_tgt = axis_tdata[31:28];
  assign w_hdr_bad = ({1'b0, w_hdr_tgt} >= 5'(NUM_TARGETS));

  // Ready of the latched target; loop avoids indexing past NUM_TARGETS with the 4-bit id.
  always_comb begin
    w_sel_ready = 1'b0;
    for (int unsigned t = 0; t < NUM_TARGETS; t++) begin
      if (r_tgt == 4'(t)) w_sel_ready = mem_wr_ready[t];
    end
  end

  always_comb begin
    case (r_state)
      S_PAYLOAD: axis_tready = w_sel_ready;
      default:   axis_tready = 1'b1;
    endcase
  end

  assign w_accept = axis_tvalid & axis_tready;

  always_comb begin
    mem_wr_en = '0;
    for (int unsigned t = 0; t < NUM_TARGETS; t++) begin
      if ((r_state == S_PAYLOAD) && w_accept && (r_tgt == 4'(t))) mem_wr_en[t] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tgt_nxt      = r_tgt;
    w_addr_nxt     = r_addr;
    w_cnt_nxt      = r_cnt;
    w_last_len_nxt = r_last_len;
    w_pkt_done_nxt = 1'b0;
    w_set_bad_tgt  = 1'b0;
    w_set_ovf      = 1'b0;
    w_cnt_inc      = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    case (r_state)
      S_HDR: begin
        if (w_accept) begin
          w_tgt_nxt  = w_hdr_tgt;
          w_addr_nxt = axis_tdata[ADDR_WIDTH-1:0];
          w_cnt_nxt  = '0;
          // A header carrying tlast is a complete empty packet, even with an unknown target.
          if (axis_tlast) begin
            w_pkt_done_nxt = 1'b1;
            w_last_len_nxt = '0;
          end else if (w_hdr_bad) begin
            w_set_bad_tgt = 1'b1;
            w_state_nxt   = S_DRAIN;
          end else begin
            w_state_nxt = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (w_accept) begin
          w_addr_nxt = r_addr + 1'b1;
          w_cnt_nxt  = w_cnt_inc;
          if (axis_tlast) begin
            w_state_nxt    = S_HDR;
            w_last_len_nxt = w_cnt_inc;
            w_pkt_done_nxt = 1'b1;
          end
`ifdef GPU_AXIS_LOADER_WRAP_GUARD_EN
          else if (r_addr == '1) begin
            w_state_nxt = S_DRAIN;
            w_set_ovf   = 1'b1;
          end
`endif
        end
      end
      S_DRAIN: begin
        if (w_accept && axis_tlast) w_state_nxt = S_HDR;
      end
      default: w_state_nxt = S_HDR;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_aresetn) begin
      r_state       <= S_HDR;
      r_tgt         <= '0;
      r_addr        <= '0;
      r_cnt         <= '0;
      r_last_len    <= '0;
      r_pkt_done    <= 1'b0;
      r_err_bad_tgt <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tgt      <= w_tgt_nxt;
      r_addr     <= w_addr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_last_len <= w_last_len_nxt;
      r_pkt_done <= w_pkt_done_nxt;
      if (w_set_bad_tgt)  r_err_bad_tgt <= 1'b1;
      else if (err_clr)   r_err_bad_tgt <= 1'b0;
    end
  end

`ifdef GPU_AXIS_LOADER_WRAP_GUARD_EN
  logic r_err_ovf;
  always_ff @(posedge axis_clk) begin
    if (!axis_aresetn)   r_err_ovf <= 1'b0;
    else if (w_set_ovf)  r_err_ovf <= 1'b1;
    else if (err_clr)    r_err_ovf <= 1'b0;
  end
  assign err_overflow = r_err_ovf;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = w_set_ovf;
`endif

  assign mem_wr_addr = r_addr;
  assign mem_wr_data = axis_tdata;
  assign mem_wr_be   = axis_tkeep;
  assign busy        = (r_state != S_HDR);
  assign pkt_done    = r_pkt_done;
  assign last_len    = r_last_len;
  assign err_bad_tgt = r_err_bad_tgt;

endmodule

// File: tb/tb_gpu_axis_loader.sv
// Randomized self-checking bench for gpu_axis_loader; expectations come from a packet-level model.
module tb_gpu_axis_loader;
  localparam int NT = 2;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tvalid, tready;
  logic [NT-1:0] mem_wr_en, mem_wr_ready;
  logic [15:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_be;
  logic        busy, pkt_done, err_bad_tgt, err_clr;
  logic [16:0] last_len;
`ifdef GPU_AXIS_LOADER_WRAP_GUARD_EN
  logic        err_overflow;
`endif

  int checks = 0;
  int errors = 0;

  logic        exp_pend_done;
  logic [16:0] exp_last_len;
  logic        exp_err;
  logic        exp_ovf;

  always #5 clk = ~clk;

  gpu_axis_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .NUM_TARGETS(NT)) dut (
    .axis_clk(clk), .axis_aresetn(aresetn),
    .axis_tdata(tdata), .axis_tkeep(tkeep), .axis_tlast(tlast),
    .axis_tvalid(tvalid), .axis_tready(tready),
    .mem_wr_en(mem_wr_en), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_be(mem_wr_be),
    .busy(busy), .pkt_done(pkt_done), .last_len(last_len),
    .err_bad_tgt(err_bad_tgt),
`ifdef GPU_AXIS_LOADER_WRAP_GUARD_EN
    .err_overflow(err_overflow),
`endif
    .err_clr(err_clr)
  );

  // Sends one packet: header then nbeats payload beats (nbeats=0 => header carries tlast).
  task automatic run_packet(input logic [3:0] tgt, input logic [15:0] base, input int nbeats,
                            input int gap_pct, input int rdy_pct, input int abort_at,
                            input bit clr_hdr);
    bit zero, bad, acc, vld, payload, sel_rdy, last;
    int drain_after;
    logic [31:0] d;
    logic [3:0]  k;
    logic [NT-1:0] rdy, exp_en;
    logic [15:0] ea;
    zero = (nbeats == 0);
    bad  = !zero && (int'(tgt) >= NT);
    drain_after = nbeats;
`ifdef GPU_AXIS_LOADER_WRAP_GUARD_EN
    if (!zero && !bad)
      for (int i = 0; i < nbeats - 1; i++)
        if (16'(int'(base) + i) == 16'hFFFF) begin drain_after = i + 1; break; end
`endif
    for (int b = 0; b <= nbeats; b++) begin
      d    = (b == 0) ? {tgt, 12'($urandom), base} : $urandom;
      k    = 4'($urandom);
      last = (b == nbeats);
      ea   = 16'(int'(base) + b - 1);
      acc  = 1'b0;
      for (int w = 0; !acc; w++) begin
        if (w > 200) begin
          checks++; errors++;
          $display("FAIL timeout beat=%0d got no accept required accept", b);
          tvalid = 1'b0; err_clr = 1'b0;
          return;
        end
        vld = ($urandom_range(99) >= gap_pct);
        for (int j = 0; j < NT; j++) rdy[j] = ($urandom_range(99) < rdy_pct);
        tvalid = vld; tdata = d; tkeep = k; tlast = last; mem_wr_ready = rdy;
        err_clr = clr_hdr && (b == 0);
        payload = (b > 0) && !bad && (b - 1 < drain_after);
        sel_rdy = 1'b1;
        exp_en  = '0;
        if (payload)
          for (int j = 0; j < NT; j++)
            if (j == int'(tgt)) begin sel_rdy = rdy[j]; exp_en[j] = vld && rdy[j]; end
        #3;
        checks++;
        if (tready !== sel_rdy) begin errors++;
          $display("FAIL tready b=%0d got %b req %b", b, tready, sel_rdy); end
        checks++;
        if (mem_wr_en !== exp_en) begin errors++;
          $display("FAIL wr_en b=%0d got %b req %b", b, mem_wr_en, exp_en); end
        if (exp_en != '0) begin
          checks++;
          if (mem_wr_addr !== ea || mem_wr_data !== d || mem_wr_be !== k) begin errors++;
            $display("FAIL wr_beat b=%0d got a=%h d=%h be=%h req a=%h d=%h be=%h",
                     b, mem_wr_addr, mem_wr_data, mem_wr_be, ea, d, k); end
        end
        checks++;
        if (pkt_done !== exp_pend_done || last_len !== exp_last_len) begin errors++;
          $display("FAIL done_len b=%0d got %b/%0d req %b/%0d", b, pkt_done, last_len,
                   exp_pend_done, exp_last_len); end
        checks++;
        if (busy !== (b > 0) || err_bad_tgt !== exp_err) begin errors++;
          $display("FAIL busy_err b=%0d got %b/%b req %b/%b", b, busy, err_bad_tgt, b > 0, exp_err); end
`ifdef GPU_AXIS_LOADER_WRAP_GUARD_EN
        checks++;
        if (err_overflow !== exp_ovf) begin errors++;
          $display("FAIL ovf b=%0d got %b req %b", b, err_overflow, exp_ovf); end
`endif
        acc = vld && sel_rdy;
        exp_pend_done = 1'b0;
        if (acc && b == 0 && bad) exp_err = 1'b1;
        else if (err_clr)         exp_err = 1'b0;
        if (acc && payload && b == drain_after && drain_after < nbeats) exp_ovf = 1'b1;
        else if (err_clr) exp_ovf = 1'b0;
        if (acc && last) begin
          if (zero) begin exp_pend_done = 1'b1; exp_last_len = '0; end
          else if (!bad && drain_after == nbeats) begin
            exp_pend_done = 1'b1; exp_last_len = 17'(nbeats);
          end
        end
        @(posedge clk); #1;
      end
      if (b > 0 && b == abort_at) begin tvalid = 1'b0; err_clr = 1'b0; return; end
    end
    tvalid = 1'b0; err_clr = 1'b0;
  endtask

  task automatic idle(input int n, input bit clr);
    for (int i = 0; i < n; i++) begin
      tvalid = 1'b0; err_clr = clr; mem_wr_ready = NT'($urandom);
      #3;
      checks++;
      if (tready !== 1'b1 || mem_wr_en !== '0 || busy !== 1'b0) begin errors++;
        $display("FAIL idle_io got rdy=%b en=%b busy=%b req 1/0/0", tready, mem_wr_en, busy); end
      checks++;
      if (pkt_done !== exp_pend_done || last_len !== exp_last_len || err_bad_tgt !== exp_err) begin
        errors++;
        $display("FAIL idle_stat got %b/%0d/%b req %b/%0d/%b", pkt_done, last_len, err_bad_tgt,
                 exp_pend_done, exp_last_len, exp_err); end
`ifdef GPU_AXIS_LOADER_WRAP_GUARD_EN
      checks++;
      if (err_overflow !== exp_ovf) begin errors++;
        $display("FAIL idle_ovf got %b req %b", err_overflow, exp_ovf); end
      if (clr) exp_ovf = 1'b0;
`endif
      exp_pend_done = 1'b0;
      if (clr) exp_err = 1'b0;
      @(posedge clk); #1;
    end
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      tvalid = 1'($urandom); tdata = $urandom; tlast = 1'($urandom); mem_wr_ready = NT'($urandom);
    end
    #3;
    checks++;
    if (busy !== 1'b0 || pkt_done !== 1'b0 || last_len !== '0 || err_bad_tgt !== 1'b0
        || mem_wr_en !== '0 || tready !== 1'b1) begin errors++;
      $display("FAIL reset got busy=%b done=%b len=%0d err=%b en=%b rdy=%b req 0/0/0/0/0/1",
               busy, pkt_done, last_len, err_bad_tgt, mem_wr_en, tready); end
    @(posedge clk); #1;
    aresetn = 1'b1; tvalid = 1'b0;
    exp_pend_done = 1'b0; exp_last_len = '0; exp_err = 1'b0; exp_ovf = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_packet(4'd1, 16'h0010, 4, 0, 100, -1, 1'b0);
    idle(2, 1'b0);
  endtask

  task automatic test_stall();
    run_packet(4'd1, 16'h0010, 4, 0, 40, -1, 1'b0);
    idle(1, 1'b0);
    run_packet(4'd0, 16'($urandom), 6, 30, 30, -1, 1'b0);
    idle(1, 1'b0);
  endtask

  task automatic test_bad_target();
    run_packet(4'd5, 16'($urandom), 3, 20, 70, -1, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    run_packet(4'd3, 16'($urandom), 2, 0, 100, -1, 1'b1);
    idle(1, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
  endtask

  task automatic test_zero_len();
    run_packet(4'd0, 16'h1234, 0, 0, 100, -1, 1'b0);
    run_packet(4'd0, 16'h0200, 2, 0, 100, -1, 1'b0);
    idle(2, 1'b0);
  endtask

  task automatic test_wrap();
    run_packet(4'd0, 16'hFFFE, 4, 0, 100, -1, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    run_packet(4'd1, 16'hFFFF, 1, 0, 100, -1, 1'b0);
    idle(2, 1'b0);
  endtask

  task automatic test_reset_mid_packet();
    run_packet(4'd0, 16'h0400, 5, 0, 100, 2, 1'b0);
    aresetn = 1'b0; tvalid = 1'b0;
    @(posedge clk); #1;
    aresetn = 1'b1;
    exp_pend_done = 1'b0; exp_last_len = '0; exp_err = 1'b0; exp_ovf = 1'b0;
    #3;
    checks++;
    if (busy !== 1'b0 || pkt_done !== 1'b0 || last_len !== '0 || err_bad_tgt !== 1'b0
        || tready !== 1'b1) begin errors++;
      $display("FAIL mid_reset got busy=%b done=%b len=%0d err=%b rdy=%b req 0/0/0/0/1",
               busy, pkt_done, last_len, err_bad_tgt, tready); end
    @(posedge clk); #1;
    run_packet(4'd1, 16'h0900, 3, 10, 80, -1, 1'b0);
    idle(2, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] base;
    for (int p = 0; p < 40; p++) begin
      base = ($urandom_range(3) == 0) ? 16'(16'hFFFB + $urandom_range(4)) : 16'($urandom);
      run_packet(4'($urandom_range(3)), base, $urandom_range(6), 25, 70, -1,
                 ($urandom_range(3) == 0));
      idle(1, ($urandom_range(3) == 0));
    end
  endtask

  initial begin
    aresetn = 1'b0; tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0;
    mem_wr_ready = '0; err_clr = 1'b0;
    exp_pend_done = 1'b0; exp_last_len = '0; exp_err = 1'b0; exp_ovf = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_bad_target();
    test_zero_len();
    test_wrap();
    test_reset_mid_packet();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpu_axis_loader.md
Name: gpu_axis_loader

Overview:
- Parametrised AXI-Stream ingress loader for the GPU data path. It replaces the fixed single-memory, 32-bit host data port.
- Each packet is parsed as one header beat followed by payload beats. Payload goes to one of NUM_TARGETS memory write ports (instruction mem, heap, framebuffer, ...).
- Generalised in data width, address width and target count. Adds byte enables, zero-length packets, bad-target draining and status reporting.

Parameters:
- DATA_WIDTH, 32, stream and memory data width; multiple of 8, >= 32.
- ADDR_WIDTH, 16, word-address width of every target port; <= 24.
- NUM_TARGETS, 2, number of memory write ports; 1..16.

Ports:
- axis_clk  in  1  single clock for all logic.
- axis_aresetn  in  1  synchronous active-low reset.
- axis_tdata  in  DATA_WIDTH  stream data.
- axis_tkeep  in  DATA_WIDTH/8  byte qualifiers.
- axis_tlast  in  1  last beat of packet.
- axis_tvalid  in  1  beat valid.
- axis_tready  out  1  beat accepted when tvalid & tready.
- mem_wr_en  out  NUM_TARGETS  one-hot write strobe.
- mem_wr_ready  in  NUM_TARGETS  per-target ready.
- mem_wr_addr  out  ADDR_WIDTH  shared word address.
- mem_wr_data  out  DATA_WIDTH  shared write data.
- mem_wr_be  out  DATA_WIDTH/8  byte enables (= tkeep).
- busy  out  1  high outside S_HDR.
- pkt_done  out  1  one-cycle pulse per completed packet.
- last_len  out  ADDR_WIDTH+1  payload beats written by last packet.
- err_bad_tgt  out  1  sticky: header target >= NUM_TARGETS.
- err_clr  in  1  clears sticky errors.

Behaviour:
- Clock and reset: single clock axis_clk; synchronous active-low reset axis_aresetn, sampled on the rising edge.
- Reset values: state=S_HDR, tgt=0, addr=0, cnt=0; busy=0, pkt_done=0, last_len=0, err_bad_tgt=0 (and err_overflow=0 when present).
- Reset mid-packet: remaining beats of the interrupted packet are treated as new headers.
- Header beat: tdata[31:28]=target id; tdata[ADDR_WIDTH-1:0]=base word address; other bits ignored.
- S_HDR: tready=1.
  - On accept: latch tgt and addr, cnt=0.
  - tlast=1 on the header: zero-length packet; stay in S_HDR, pulse pkt_done next cycle, last_len=0.
  - Else if tgt >= NUM_TARGETS: set err_bad_tgt, go to S_DRAIN.
  - Else go to S_PAYLOAD.
- S_PAYLOAD: tready = mem_wr_ready[tgt].
  - Write strobes are combinational: mem_wr_en[tgt] = tvalid & tready; other bits 0.
  - mem_wr_addr=addr, mem_wr_data=tdata, mem_wr_be=tkeep; zero write latency.
  - On accept: addr+=1, cnt+=1.
  - On accept with tlast: go to S_HDR, last_len = cnt+1, pkt_done pulses the following cycle.
  - A beat with tkeep=0 is still written with be=0 and counts toward last_len.
- S_DRAIN: tready=1, no writes. On accepting tlast, go to S_HDR; no pkt_done, last_len unchanged.
- Address wrap: addr wraps modulo 2^ADDR_WIDTH (macro absent).
- cnt saturates at 2^ADDR_WIDTH.
- Error flags: err_clr clears sticky flags. If err_clr coincides with a new error, the error wins (flag stays 1).
- Flow control:
  - tvalid deasserting mid-packet holds state.
  - mem_wr_ready low stalls the stream; tready=0, no write, addr held.
- busy = (state != S_HDR).
- Combinational paths: only tready and mem_wr_en may depend combinationally on inputs; all other outputs are registered.

Optional Feature:
- Macro: GPU_AXIS_LOADER_WRAP_GUARD_EN.
- Defined:
  - Adds sticky output err_overflow (1 bit), cleared by err_clr.
  - A payload beat accepted at addr = 2^ADDR_WIDTH-1 is written, then the block enters S_DRAIN with err_overflow set, unless that beat had tlast.
  - Following beats are discarded through tlast; no pkt_done.
- Undefined: port absent; address wraps silently to 0 and the packet completes normally.

Test Plan:
- Header tgt=1, base=0x0010, then 4 payload beats 0xA0..0xA3, last with tlast, ready held high -> mem_wr_en=2'b10 on 4 consecutive cycles, addr 0x10..0x13; pkt_done pulses once; last_len=4; busy low after.
- Same packet with mem_wr_ready[1] low for 3 cycles mid-payload -> tready=0 during the stall, no duplicate or skipped address, last_len=4.
- Header tgt=5 (NUM_TARGETS=2), 3 payload beats -> no mem_wr_en; err_bad_tgt=1 and stays 1; no pkt_done; err_clr pulse -> 0.
- Header with tlast=1, tgt=0 -> zero writes, pkt_done pulses, last_len=0, next beat parsed as header.
- Base=0xFFFE, 4 beats -> macro off: writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001, last_len=4. Macro on: 2 writes, err_overflow=1, remainder drained, no pkt_done.
- Reset asserted mid-payload after 2 beats -> next cycle state S_HDR, busy=0, outputs at reset values; next beat treated as header.
